reg_file_sb: RTL

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 24 ++
 rtl/reg_scoreboard.sv | 77 +++++++
 rtl/reg_file_sb.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
//
// Purpose
//   Shared constants and types for the register file with scoreboard
//   (reg_file_sb) and its busy-bit tracker (reg_scoreboard).
//
// Contents
//   DEFAULT_WIDTH  default data word width in bits
//   DEFAULT_DEPTH  default number of architectural registers
//   DEFAULT_AW     register address width for the default depth
//   reg_addr_t     register address sized for the default depth
//   reg_data_t     data word sized for the default width
// ---------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_AW-1:0]    reg_addr_t;
    typedef logic [DEFAULT_WIDTH-1:0] reg_data_t;

endpackage : reg_file_pkg

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Purpose
//   One pending-write ("busy") bit per register. An accepted issue sets the
//   bit of the claimed destination; a register write clears the bit of the
//   written destination. When both target the same register in one cycle the
//   issue wins, so the bit ends up set (the new producer is still in flight).
//
// Ports
//   clk          in   sole clock, state updates on posedge
//   reset_n      in   synchronous active-low reset, clears every busy bit
//   issue_valid  in   request to claim issue_dr
//   issue_dr     in   destination being claimed
//   wr_en        in   register write happening this cycle
//   wr_addr      in   destination of that write
//   busy_vec     out  registered busy bits, bit i = register i
//   accept       out  issue taken this cycle (0 while in reset)
// ---------------------------------------------------------------------------
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter bit ZERO_R0 = 1'b0,
    // Derived from DEPTH; not meant to be overridden.
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_dr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    output logic [DEPTH-1:0] busy_vec,
    output logic             accept
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             target_busy;
    logic             write_frees_target;

    // A busy destination can still be claimed when the write that frees it
    // lands in the same cycle: the old producer retires as the new one issues.
    always_comb begin
        target_busy        = busy_q[issue_dr];
        write_frees_target = wr_en && (wr_addr == issue_dr);
        accept             = reset_n && issue_valid &&
                             (!target_busy || write_frees_target);
    end

    // Clear first, then set, so a same-cycle issue overrides the write's clear.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (accept) begin
            busy_d[issue_dr] = 1'b1;
        end
        // A hard-wired zero register never has a pending producer.
        if (ZERO_R0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//
// Purpose
//   DEPTH x WIDTH register file with one write port, two combinational read
//   ports, optional write-through forwarding, optional hard-wired zero
//   register, and a busy-bit scoreboard for in-flight destinations.
//
// Ports
//   Clk          in   sole clock, state updates on posedge
//   Reset_n      in   synchronous active-low reset (array and busy bits to 0)
//   LD_REG       in   write enable
//   DR           in   write destination
//   data_in      in   write data
//   SR1, SR2     in   read addresses
//   SR1_output   out  read data, port 1 (combinational)
//   SR2_output   out  read data, port 2 (combinational)
//   issue_valid  in   request to mark issue_dr pending
//   issue_dr     in   destination claimed by an in-flight instruction
//   issue_stall  out  issue rejected this cycle (combinational)
//   SR1_busy     out  register SR1 has a pending write
//   SR2_busy     out  register SR2 has a pending write
//   busy_vec     out  full pending-bit vector, bit i = register i
//
// Issue handshake
//   issue_valid is the request and issue_stall is the (inverted) ready: an
//   issue is taken at posedge exactly when issue_valid=1 and issue_stall=0 in
//   that cycle. A stalled request changes nothing; the requester keeps
//   issue_valid/issue_dr stable and retries. issue_stall never depends on
//   anything registered later than the current cycle, and is 0 in reset.
// ---------------------------------------------------------------------------
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = DEFAULT_DEPTH,
    // Derived from DEPTH; not meant to be overridden.
    parameter int AW      = $clog2(DEPTH),
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             LD_REG,
    input  logic [AW-1:0]    DR,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    SR1,
    input  logic [AW-1:0]    SR2,
    output logic [WIDTH-1:0] SR1_output,
    output logic [WIDTH-1:0] SR2_output,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_dr,
    output logic             issue_stall,
    output logic             SR1_busy,
    output logic             SR2_busy,
    output logic [DEPTH-1:0] busy_vec
);

    localparam int NUM_RD = 2;

    logic [WIDTH-1:0] regs [DEPTH];

    logic             wr_allowed;
    logic             fwd_data;
    logic             fwd_clear;
    logic             issue_accept;

    logic [AW-1:0]    rd_addr [NUM_RD];
    logic [WIDTH-1:0] rd_data [NUM_RD];
    logic             rd_busy [NUM_RD];

    // -----------------------------------------------------------------------
    // Write side
    // -----------------------------------------------------------------------

    // Writes to a hard-wired zero register are dropped before reaching the
    // array, so forwarding for that address is suppressed by the same term.
    assign wr_allowed = LD_REG && !(ZERO_R0 && (DR == '0));

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_allowed) begin
            regs[DR] <= data_in;
        end
    end

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------

    reg_scoreboard #(
        .DEPTH   (DEPTH),
        .ZERO_R0 (ZERO_R0),
        .AW      (AW)
    ) u_scoreboard (
        .clk         (Clk),
        .reset_n     (Reset_n),
        .issue_valid (issue_valid),
        .issue_dr    (issue_dr),
        .wr_en       (LD_REG),
        .wr_addr     (DR),
        .busy_vec    (busy_vec),
        .accept      (issue_accept)
    );

    // In reset the accept term is already forced low; the Reset_n factor
    // keeps the stall low as well, since nothing is being refused.
    assign issue_stall = issue_valid && Reset_n && !issue_accept;

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------

    // A write presented during reset is discarded, so it must not be
    // forwarded either: reads then show the array as it is.
    assign fwd_data  = BYPASS && Reset_n && wr_allowed;
    assign fwd_clear = BYPASS && Reset_n && LD_REG;

    assign rd_addr[0] = SR1;
    assign rd_addr[1] = SR2;

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            if (fwd_data && (DR == rd_addr[p])) begin
                rd_data[p] = data_in;
            end
            if (ZERO_R0 && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
            end

            // With forwarding the reader already sees the retiring value, so
            // the register is not busy for it -- unless a new producer claims
            // the same register in this cycle.
            rd_busy[p] = busy_vec[rd_addr[p]];
            if (fwd_clear && (DR == rd_addr[p]) &&
                !(issue_accept && (issue_dr == rd_addr[p]))) begin
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign SR1_output = rd_data[0];
    assign SR2_output = rd_data[1];
    assign SR1_busy   = rd_busy[0];
    assign SR2_busy   = rd_busy[1];

endmodule : reg_file_sb
